// File: rtl/stream_arg_select.sv
// stream_arg_select: reduces a framed (data, index) stream to its arg-max or
// arg-min element under a valid/ready result handshake.
// The comparison uses only the field in_dat[hi:lo], compared unsigned. The
// whole word is still carried to out_dat.
// Optional macro ARG_SELECT_TIE_LATEST_EN: when the compared fields are
// equal, the newer element wins. When the macro is undefined, the earliest
// element wins.
module stream_arg_select #(
  parameter int data_wd   = 16,
  parameter int idx_wd    = 4,
  parameter int hi        = 15,
  parameter int lo        = 0,
  parameter int frame_len = 16,
  localparam int cnt_wd   = $clog2(frame_len + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [data_wd-1:0] in_dat,
  input  logic [idx_wd-1:0]  in_idx,
  input  logic               in_dv,
  input  logic               in_last,
  input  logic               great_n_small,
  output logic               in_rdy,
  output logic [data_wd-1:0] out_dat,
  output logic [idx_wd-1:0]  out_idx,
  output logic [cnt_wd-1:0]  out_cnt,
  output logic               out_dv,
  input  logic               out_rdy
);

  localparam int fld_wd = hi - lo + 1;

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t             state_q, state_d;
  logic [data_wd-1:0] best_dat_q, best_dat_d;
  logic [idx_wd-1:0]  best_idx_q, best_idx_d;
  logic [cnt_wd-1:0]  cnt_q, cnt_d;
  logic               mode_q;
  logic [data_wd-1:0] out_dat_q;
  logic [idx_wd-1:0]  out_idx_q;
  logic [cnt_wd-1:0]  out_cnt_q;

  logic              beat;
  logic              first;
  logic              take_new;
  logic              close;
  logic [fld_wd-1:0] fld_in;
  logic [fld_wd-1:0] fld_best;

  assign fld_in   = in_dat[hi:lo];
  assign fld_best = best_dat_q[hi:lo];
  assign beat     = in_dv && in_rdy;
  assign first    = (state_q == IDLE);

  // Decide whether the incoming element replaces the current best, and build the running result.
  always_comb begin
`ifdef ARG_SELECT_TIE_LATEST_EN
    take_new = mode_q ? (fld_in >= fld_best) : (fld_in <= fld_best);
`else
    take_new = mode_q ? (fld_in > fld_best) : (fld_in < fld_best);
`endif
    best_dat_d = best_dat_q;
    best_idx_d = best_idx_q;
    cnt_d      = cnt_q;
    if (first) begin
      best_dat_d = in_dat;
      best_idx_d = in_idx;
      cnt_d      = cnt_wd'(1);
    end else begin
      cnt_d = cnt_q + cnt_wd'(1);
      if (take_new) begin
        best_dat_d = in_dat;
        best_idx_d = in_idx;
      end
    end
    // The frame closes on in_last, or when the count reaches frame_len (whichever comes first).
    close = beat && (in_last || (cnt_d == cnt_wd'(frame_len)));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (beat) state_d = close ? HOLD : ACC;
      ACC:     if (close) state_d = HOLD;
      HOLD:    if (out_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are decoded from registered state only, so there is no path from out_rdy to in_rdy.
  always_comb begin
    in_rdy = (state_q != HOLD);
    out_dv = (state_q == HOLD);
  end

  // Accumulator and result registers. Results stay in place after handoff until the next frame closes.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_dat_q <= '0;
      best_idx_q <= '0;
      cnt_q      <= '0;
      mode_q     <= 1'b0;
      out_dat_q  <= '0;
      out_idx_q  <= '0;
      out_cnt_q  <= '0;
    end else if (beat) begin
      best_dat_q <= best_dat_d;
      best_idx_q <= best_idx_d;
      cnt_q      <= cnt_d;
      if (first) mode_q <= great_n_small;
      if (close) begin
        out_dat_q <= best_dat_d;
        out_idx_q <= best_idx_d;
        out_cnt_q <= cnt_d;
      end
    end
  end

  assign out_dat = out_dat_q;
  assign out_idx = out_idx_q;
  assign out_cnt = out_cnt_q;

endmodule

// File: tb/tb_stream_arg_select.sv
// Testbench for stream_arg_select.
// Table-driven frames are checked against a scoreboard queue. Hand-written
// sequences cover the remaining cases: a forced end at frame_len, the result
// hold, resets, and a narrow compare field.
module tb_stream_arg_select;

`ifdef ARG_SELECT_TIE_LATEST_EN
  localparam bit LATEST = 1'b1;
`else
  localparam bit LATEST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_dat = '0;
  logic [3:0]  in_idx = '0;
  logic        in_dv = 1'b0;
  logic        in_last = 1'b0;
  logic        great_n_small = 1'b0;
  logic        out_rdy = 1'b0;
  logic        in_rdy, out_dv;
  logic [15:0] out_dat;
  logic [3:0]  out_idx;
  logic [4:0]  out_cnt;
  logic        n_in_rdy, n_out_dv;
  logic [15:0] n_out_dat;
  logic [3:0]  n_out_idx;
  logic [4:0]  n_out_cnt;

  always #5 clk = ~clk;

  stream_arg_select dut (
    .clk(clk), .rst(rst), .in_dat(in_dat), .in_idx(in_idx), .in_dv(in_dv),
    .in_last(in_last), .great_n_small(great_n_small), .in_rdy(in_rdy),
    .out_dat(out_dat), .out_idx(out_idx), .out_cnt(out_cnt), .out_dv(out_dv),
    .out_rdy(out_rdy)
  );

  // Same stream, but only bits [7:4] take part in the comparison.
  stream_arg_select #(.hi(7), .lo(4)) u_nib (
    .clk(clk), .rst(rst), .in_dat(in_dat), .in_idx(in_idx), .in_dv(in_dv),
    .in_last(in_last), .great_n_small(great_n_small), .in_rdy(n_in_rdy),
    .out_dat(n_out_dat), .out_idx(n_out_idx), .out_cnt(n_out_cnt), .out_dv(n_out_dv),
    .out_rdy(out_rdy)
  );

  typedef struct packed {
    logic            mode;
    logic            tog;
    logic            gap;
    logic [2:0]      n;
    logic [3:0][15:0] d;
    logic [3:0][3:0]  x;
    logic [15:0]     ed;
    logic [3:0]      ei;
    logic [4:0]      ec;
  } vec_t;

  typedef struct packed {
    logic [15:0] dat;
    logic [3:0]  idx;
    logic [4:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit mode, bit tog, bit gap, int n,
                              int d0, int d1, int d2, int d3,
                              int x0, int x1, int x2, int x3,
                              int ed, int ei, int ec);
    vec_t v;
    v = '0;
    v.mode = mode; v.tog = tog; v.gap = gap; v.n = 3'(n);
    v.d[0] = 16'(d0); v.d[1] = 16'(d1); v.d[2] = 16'(d2); v.d[3] = 16'(d3);
    v.x[0] = 4'(x0); v.x[1] = 4'(x1); v.x[2] = 4'(x2); v.x[3] = 4'(x3);
    v.ed = 16'(ed); v.ei = 4'(ei); v.ec = 5'(ec);
    return v;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the beat edge.
  task automatic drive_beat(input logic [15:0] d, input logic [3:0] x, input logic last, input logic mode);
    in_dat = d; in_idx = x; in_last = last; great_n_small = mode; in_dv = 1'b1;
    @(posedge clk); #1;
    in_dv = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_vec(input vec_t v);
    exp_t e;
    for (int i = 0; i < int'(v.n); i++) begin
      if (i == int'(v.n) - 1) begin
        e.dat = v.ed; e.idx = v.ei; e.cnt = v.ec;
        sb.push_back(e);
        chk("pre_close_dv", 32'(out_dv), 32'd0);
      end
      drive_beat(v.d[i], v.x[i], (i == int'(v.n) - 1),
                 (i == 0) ? v.mode : (v.tog ? ~v.mode : v.mode));
      if (v.gap && i != int'(v.n) - 1) begin
        @(posedge clk); #1;
      end
    end
    $display("frame mode=%0d n=%0d sent, expect dat=%h idx=%0d cnt=%0d", v.mode, v.n, v.ed, v.ei, v.ec);
  endtask

  task automatic take_result(input int hold, input string tag);
    exp_t e;
    int w = 0;
    while (!out_dv && w < 20) begin
      @(posedge clk); #1; w++;
    end
    chk({tag, "_dv"}, 32'(out_dv), 32'd1);
    chk({tag, "_latency"}, 32'(w), 32'd0);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_dat"}, 32'(out_dat), 32'(e.dat));
    chk({tag, "_idx"}, 32'(out_idx), 32'(e.idx));
    chk({tag, "_cnt"}, 32'(out_cnt), 32'(e.cnt));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_dv"}, 32'(out_dv), 32'd1);
      chk({tag, "_hold_rdy"}, 32'(in_rdy), 32'd0);
      chk({tag, "_hold_dat"}, 32'(out_dat), 32'(e.dat));
      chk({tag, "_hold_idx"}, 32'(out_idx), 32'(e.idx));
    end
    in_dv = 1'b0;
    out_rdy = 1'b1;
    @(posedge clk); #1;
    out_rdy = 1'b0;
    chk({tag, "_post_dv"}, 32'(out_dv), 32'd0);
    chk({tag, "_post_rdy"}, 32'(in_rdy), 32'd1);
    chk({tag, "_post_keep"}, 32'(out_dat), 32'(e.dat));
    $display("result %s: dat=%h idx=%0d cnt=%0d (exp %h/%0d/%0d)", tag, out_dat, out_idx, out_cnt, e.dat, e.idx, e.cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[7];
    exp_t e;
    logic [15:0] fd;
    logic [15:0] bd;
    logic [3:0]  bi;

    vt[0] = mk(1, 0, 0, 4, 3, 1, 7, 2, 0, 1, 2, 3, 7, 2, 4);
    vt[1] = mk(0, 1, 0, 4, 3, 1, 7, 2, 0, 1, 2, 3, 1, 1, 4);
    vt[2] = mk(1, 0, 0, 3, 5, 5, 5, 0, 4, 5, 6, 0, 5, LATEST ? 6 : 4, 3);
    vt[3] = mk(0, 0, 0, 1, 'hABCD, 0, 0, 0, 9, 0, 0, 0, 'hABCD, 9, 1);
    vt[4] = mk(0, 0, 1, 3, 2, 8, 2, 0, 1, 2, 3, 0, 2, LATEST ? 3 : 1, 3);
    vt[5] = mk(1, 0, 0, 3, 'hFFFF, 0, 'hFFFE, 0, 7, 8, 9, 0, 'hFFFF, 7, 3);
    vt[6] = mk(0, 0, 1, 4, 5, 0, 3, 0, 0, 1, 2, 3, 0, LATEST ? 3 : 1, 4);

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    chk("rst_dv", 32'(out_dv), 32'd0);
    chk("rst_rdy", 32'(in_rdy), 32'd1);
    chk("rst_dat", 32'(out_dat), 32'd0);
    chk("rst_idx", 32'(out_idx), 32'd0);
    chk("rst_cnt", 32'(out_cnt), 32'd0);

    // Table-driven frames
    for (int i = 0; i < 7; i++) begin
      send_vec(vt[i]);
      take_result(i % 3, $sformatf("vec%0d", i));
    end

    // Forced end at frame_len, with a 17th element held off and a 5-cycle result hold
    bd = '0; bi = '0;
    for (int i = 0; i < 16; i++) begin
      fd = 16'((i * 40503 + 977) & 16'hFFFF);
      if (i == 0 || fd > bd) begin
        bd = fd; bi = 4'(i);
      end
      drive_beat(fd, 4'(i), 1'b0, 1'b1);
    end
    e.dat = bd; e.idx = bi; e.cnt = 5'd16;
    sb.push_back(e);
    chk("force_dv", 32'(out_dv), 32'd1);
    chk("force_rdy", 32'(in_rdy), 32'd0);
    chk("force_cnt", 32'(out_cnt), 32'd16);
    in_dat = 16'hFFFF; in_idx = 4'hF; in_dv = 1'b1; great_n_small = 1'b1;
    take_result(5, "force");
    chk("force_cnt_keep", 32'(out_cnt), 32'd16);
    repeat (2) @(posedge clk);
    #1;
    chk("force_no17_dv", 32'(out_dv), 32'd0);

    // Narrow compare field on u_nib; bits outside it are carried through
    send_vec(mk(1, 0, 0, 2, 'hF01F, 'h002A, 0, 0, 3, 7, 0, 0, 'hF01F, 3, 2));
    chk("nib_dv", 32'(n_out_dv), 32'd1);
    chk("nib_dat", 32'(n_out_dat), 32'h002A);
    chk("nib_idx", 32'(n_out_idx), 32'd7);
    chk("nib_cnt", 32'(n_out_cnt), 32'd2);
    take_result(1, "nib_main");

    // Reset mid-frame: the partial frame is discarded, then a fresh frame works
    drive_beat(16'd9, 4'd1, 1'b0, 1'b1);
    drive_beat(16'd50, 4'd2, 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_dv", 32'(out_dv), 32'd0);
    chk("midrst_rdy", 32'(in_rdy), 32'd1);
    chk("midrst_cnt", 32'(out_cnt), 32'd0);
    chk("midrst_dat", 32'(out_dat), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_quiet", 32'(out_dv), 32'd0);
    send_vec(mk(0, 0, 0, 2, 9, 4, 0, 0, 1, 2, 0, 0, 4, 2, 2));
    take_result(0, "fresh");

    // Reset while in HOLD: the result is discarded
    send_vec(mk(1, 0, 0, 2, 1, 2, 0, 0, 1, 2, 0, 0, 2, 2, 2));
    chk("holdrst_pre_dv", 32'(out_dv), 32'd1);
    void'(sb.pop_front());
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("holdrst_dv", 32'(out_dv), 32'd0);
    chk("holdrst_rdy", 32'(in_rdy), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
